// File: rtl/bbox_scanner_if.sv
// rtl/bbox_scanner_if.sv - byte read bus between the bbox scanner and pixel memory
interface bbox_scanner_if #(
   parameter int ADDR_W = 32
);
   logic              rd_req;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        rddata;
   logic              rd_valid;

   modport master (output rd_req, output addr, input rddata, input rd_valid);
   modport slave  (input rd_req, input addr, output rddata, output rd_valid);
endinterface

// File: rtl/bbox_scanner.sv
// rtl/bbox_scanner.sv - foreground bounding-box scanner over a packed-pixel bitmap
module bbox_scanner #(
   parameter int BPP     = 3,
   parameter int COORD_W = 11,
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 22
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [COORD_W-1:0] i_width,
   input  logic [COORD_W-1:0] i_height,
   input  logic [ADDR_W-1:0]  i_base_addr,
   input  logic [7:0]         i_threshold,
   input  logic               i_bottom_up,
   input  logic               i_pad4,
   input  logic               i_all_ch,
   bbox_scanner_if.master     mem,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_found,
   output logic [COORD_W-1:0] o_x_min,
   output logic [COORD_W-1:0] o_x_max,
   output logic [COORD_W-1:0] o_y_min,
   output logic [COORD_W-1:0] o_y_max,
   output logic [CNT_W-1:0]   o_fg_count
);

   localparam int CH_W = (BPP > 1) ? $clog2(BPP) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(BPP - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_FETCH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         r_state;
   logic [COORD_W-1:0] r_width;
   logic [COORD_W-1:0] r_height;
   logic [ADDR_W-1:0]  r_base;
   logic [7:0]         r_thr;
   logic               r_bottom_up;
   logic               r_pad4;
   logic               r_all_ch;
   logic [ADDR_W-1:0]  r_stride;
   logic [ADDR_W-1:0]  r_row_base;
   logic [ADDR_W-1:0]  r_addr;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [CH_W-1:0]    r_ch;
   logic               r_acc;

   logic               r_found;
   logic [COORD_W-1:0] r_x_min;
   logic [COORD_W-1:0] r_x_max;
   logic [COORD_W-1:0] r_y_min;
   logic [COORD_W-1:0] r_y_max;
   logic [CNT_W-1:0]   r_fg_count;

   logic [ADDR_W-1:0]  w_stride_raw;
   logic [ADDR_W-1:0]  w_stride;
   logic [ADDR_W-1:0]  w_first_row;
   logic [ADDR_W-1:0]  w_next_row;
   logic               w_start_ok;
   logic               w_accept;
   logic               w_byte_fg;
   logic               w_pix_fg;
   logic               w_last_ch;
   logic               w_last_x;
   logic               w_last_y;
   logic               w_hit;
   logic               w_empty;

   // Stride and first-row address are only consumed in SETUP, from latched config.
   assign w_stride_raw = ADDR_W'(r_width) * ADDR_W'(BPP);
   assign w_stride     = r_pad4 ? ((w_stride_raw + ADDR_W'(3)) & ~ADDR_W'(3)) : w_stride_raw;
   assign w_first_row  = r_bottom_up ? (r_base + (ADDR_W'(r_height) - ADDR_W'(1)) * w_stride)
                                     : r_base;
   assign w_next_row   = r_bottom_up ? (r_row_base - r_stride) : (r_row_base + r_stride);
   assign w_empty      = (r_width == '0) || (r_height == '0);

   assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_accept   = (r_state == S_FETCH) && mem.rd_valid;
   assign w_byte_fg  = (mem.rddata < r_thr);
   // First channel seeds the pixel flag; later channels fold in with AND or OR.
   assign w_pix_fg   = (r_ch == '0) ? w_byte_fg
                     : (r_all_ch ? (r_acc & w_byte_fg) : (r_acc | w_byte_fg));
   assign w_last_ch  = (r_ch == LAST_CH);
   assign w_last_x   = (r_x == r_width - COORD_W'(1));
   assign w_last_y   = (r_y == r_height - COORD_W'(1));
   assign w_hit      = w_accept && w_last_ch && w_pix_fg;

   assign mem.rd_req = (r_state == S_FETCH);
   assign mem.addr   = r_addr;
   assign o_busy     = (r_state == S_SETUP) || (r_state == S_FETCH);
   assign o_done     = (r_state == S_DONE);
   assign o_found    = r_found;
   assign o_x_min    = r_x_min;
   assign o_x_max    = r_x_max;
   assign o_y_min    = r_y_min;
   assign o_y_max    = r_y_max;
   assign o_fg_count = r_fg_count;

   // Scan control: config latch, address walk (byte increment, row jump) and state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_width     <= '0;
         r_height    <= '0;
         r_base      <= '0;
         r_thr       <= '0;
         r_bottom_up <= 1'b0;
         r_pad4      <= 1'b0;
         r_all_ch    <= 1'b0;
         r_stride    <= '0;
         r_row_base  <= '0;
         r_addr      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_ch        <= '0;
         r_acc       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_width     <= i_width;
                  r_height    <= i_height;
                  r_base      <= i_base_addr;
                  r_thr       <= i_threshold;
                  r_bottom_up <= i_bottom_up;
                  r_pad4      <= i_pad4;
                  r_all_ch    <= i_all_ch;
                  r_state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_stride   <= w_stride;
               r_row_base <= w_first_row;
               r_addr     <= w_first_row;
               r_x        <= '0;
               r_y        <= '0;
               r_ch       <= '0;
               r_acc      <= 1'b0;
               r_state    <= w_empty ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
               if (mem.rd_valid) begin
                  r_acc <= w_pix_fg;
                  if (!w_last_ch) begin
                     r_ch   <= r_ch + CH_W'(1);
                     r_addr <= r_addr + ADDR_W'(1);
                  end else begin
                     r_ch <= '0;
                     if (!w_last_x) begin
                        r_x    <= r_x + COORD_W'(1);
                        r_addr <= r_addr + ADDR_W'(1);
                     end else begin
                        r_x <= '0;
                        if (w_last_y) begin
                           r_state <= S_DONE;
                        end else begin
                           r_y        <= r_y + COORD_W'(1);
                           r_row_base <= w_next_row;
                           r_addr     <= w_next_row;
                        end
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Results: cleared on an accepted start, updated on the last byte of a foreground pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_found    <= 1'b0;
         r_x_min    <= '0;
         r_x_max    <= '0;
         r_y_min    <= '0;
         r_y_max    <= '0;
         r_fg_count <= '0;
      end else if (w_start_ok) begin
         r_found    <= 1'b0;
         r_x_min    <= '0;
         r_x_max    <= '0;
         r_y_min    <= '0;
         r_y_max    <= '0;
         r_fg_count <= '0;
      end else if (w_hit) begin
         if (!r_found) begin
            r_x_min <= r_x;
            r_x_max <= r_x;
            r_y_min <= r_y;
            r_y_max <= r_y;
         end else begin
            if (r_x < r_x_min) r_x_min <= r_x;
            if (r_x > r_x_max) r_x_max <= r_x;
            if (r_y < r_y_min) r_y_min <= r_y;
            if (r_y > r_y_max) r_y_max <= r_y;
         end
         r_found <= 1'b1;
         if (!(&r_fg_count)) r_fg_count <= r_fg_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bbox_scanner.sv
// tb/tb_bbox_scanner.sv - randomized self-checking bench for bbox_scanner
module tb_bbox_scanner;

   localparam int BPP     = 3;
   localparam int COORD_W = 11;
   localparam int ADDR_W  = 32;
   localparam int CNT_W   = 22;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               i_start = 1'b0;
   logic [COORD_W-1:0] i_width = '0;
   logic [COORD_W-1:0] i_height = '0;
   logic [ADDR_W-1:0]  i_base_addr = '0;
   logic [7:0]         i_threshold = '0;
   logic               i_bottom_up = 1'b0;
   logic               i_pad4 = 1'b0;
   logic               i_all_ch = 1'b0;
   logic               o_busy, o_done, o_found;
   logic [COORD_W-1:0] o_x_min, o_x_max, o_y_min, o_y_max;
   logic [CNT_W-1:0]   o_fg_count;

   bbox_scanner_if #(.ADDR_W(ADDR_W)) mem_if ();

   bbox_scanner #(.BPP(BPP), .COORD_W(COORD_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_width(i_width), .i_height(i_height),
      .i_base_addr(i_base_addr), .i_threshold(i_threshold), .i_bottom_up(i_bottom_up),
      .i_pad4(i_pad4), .i_all_ch(i_all_ch), .mem(mem_if), .o_busy(o_busy), .o_done(o_done),
      .o_found(o_found), .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min),
      .o_y_max(o_y_max), .o_fg_count(o_fg_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem [0:4095];
   logic [7:0] img [0:7][0:7][0:3];

   int          stall_pct = 0;
   int          req_cycles = 0;
   int          stall_cycles = 0;
   int          stab_err = 0;
   logic [31:0] q_addr[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Memory: answers the request on the same cycle or stalls at random; junk rd_valid when idle.
   initial begin
      logic        prev_req, prev_valid;
      logic [31:0] prev_addr;
      prev_req = 0; prev_valid = 0; prev_addr = 0;
      mem_if.rd_valid = 0;
      mem_if.rddata = 0;
      forever begin
         @(negedge clk);
         if (mem_if.rd_req === 1'b1) begin
            req_cycles++;
            if (prev_req && !prev_valid && (mem_if.addr !== prev_addr)) stab_err++;
            mem_if.rd_valid = ($urandom_range(99) >= stall_pct);
            mem_if.rddata = mem[mem_if.addr[11:0]];
            if (mem_if.rd_valid) q_addr.push_back(mem_if.addr);
            else stall_cycles++;
         end else begin
            mem_if.rd_valid = 1'($urandom_range(1));
            mem_if.rddata = 8'($urandom_range(255));
         end
         prev_req = (mem_if.rd_req === 1'b1);
         prev_valid = mem_if.rd_valid;
         prev_addr = mem_if.addr;
      end
   end

   task automatic fill_img(input logic [7:0] v);
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            for (int c = 0; c < 4; c++) img[y][x][c] = v;
   endtask

   task automatic rand_img(input int w, input int h, input int thr);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            for (int c = 0; c < BPP; c++)
               img[y][x][c] = ($urandom_range(2) == 0) ? 8'($urandom_range(thr)) : 8'($urandom_range(255, thr));
   endtask

   function automatic int row_off(input int y, input int h, input int stride, input bit bu);
      return bu ? (h - 1 - y) * stride : y * stride;
   endfunction

   // Lays the image out in memory; padding and unused bytes are 0 so any stray read is visible.
   task automatic load_mem(input int w, input int h, input int base, input int stride, input bit bu);
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            for (int c = 0; c < BPP; c++)
               mem[base + row_off(y, h, stride, bu) + x * BPP + c] = img[y][x][c];
   endtask

   task automatic start_scan(input int w, input int h, input int base, input int thr,
                             input bit bu, input bit pad, input bit allch);
      @(negedge clk);
      q_addr.delete();
      req_cycles = 0; stall_cycles = 0; stab_err = 0;
      i_width = COORD_W'(w); i_height = COORD_W'(h); i_base_addr = ADDR_W'(base);
      i_threshold = 8'(thr); i_bottom_up = bu; i_pad4 = pad; i_all_ch = allch;
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      i_width = COORD_W'($urandom_range(7)); i_height = COORD_W'($urandom_range(7));
      i_threshold = 8'($urandom_range(255));
   endtask

   task automatic run_scan(input string tag, input int w, input int h, input int base, input int thr,
                           input bit bu, input bit pad, input bit allch, input int stall, input bit poke);
      int stride, n, lat, busy_n, e_cnt, pad_hits, k, rel;
      bit ex_found, fg, timed_out;
      int ex_x0, ex_x1, ex_y0, ex_y1, ex_cnt;
      stride = w * BPP;
      if (pad) stride = ((stride + 3) / 4) * 4;
      load_mem(w, h, base, stride, bu);
      ex_found = 0; ex_x0 = 0; ex_x1 = 0; ex_y0 = 0; ex_y1 = 0; ex_cnt = 0;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            fg = allch;
            for (int c = 0; c < BPP; c++)
               if (allch) fg = fg && (img[y][x][c] < thr);
               else       fg = fg || (img[y][x][c] < thr);
            if (fg) begin
               if (!ex_found) begin ex_x0 = x; ex_x1 = x; ex_y0 = y; ex_y1 = y; end
               else begin
                  if (x < ex_x0) ex_x0 = x;
                  if (x > ex_x1) ex_x1 = x;
                  if (y < ex_y0) ex_y0 = y;
                  if (y > ex_y1) ex_y1 = y;
               end
               ex_found = 1; ex_cnt++;
            end
         end
      n = (w == 0 || h == 0) ? 0 : w * h * BPP;
      stall_pct = stall;
      start_scan(w, h, base, thr, bu, pad, allch);
      busy_n = o_busy;
      lat = 0; timed_out = 1;
      while (lat < 5000) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (o_done) begin timed_out = 0; break; end
         busy_n += o_busy;
         if (poke && lat == 4) begin
            i_start = 1'b1; i_width = COORD_W'(1); i_height = COORD_W'(1);
         end
         if (poke && lat == 5) i_start = 1'b0;
      end
      i_start = 1'b0;
      check({tag, "/timeout"}, timed_out, 0);
      check({tag, "/latency"}, lat, n + 1 + stall_cycles);
      check({tag, "/busy_cycles"}, busy_n, n + 1 + stall_cycles);
      check({tag, "/req_cycles"}, req_cycles, n + stall_cycles);
      check({tag, "/found"}, o_found, ex_found);
      check({tag, "/x_min"}, o_x_min, ex_x0);
      check({tag, "/x_max"}, o_x_max, ex_x1);
      check({tag, "/y_min"}, o_y_min, ex_y0);
      check({tag, "/y_max"}, o_y_max, ex_y1);
      check({tag, "/fg_count"}, o_fg_count, ex_cnt);
      check({tag, "/addr_stable"}, stab_err, 0);
      e_cnt = (q_addr.size() != n) ? 1 : 0;
      pad_hits = 0;
      k = 0;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            for (int c = 0; c < BPP; c++) begin
               if (k < q_addr.size() && q_addr[k] != 32'(base + row_off(y, h, stride, bu) + x * BPP + c))
                  e_cnt++;
               k++;
            end
      foreach (q_addr[i]) begin
         rel = int'(q_addr[i]) - base;
         if (stride > 0 && (rel < 0 || (rel % stride) >= w * BPP)) pad_hits++;
      end
      check({tag, "/addr_seq"}, e_cnt, 0);
      check({tag, "/pad_reads"}, pad_hits, 0);
      if (n > 0 && q_addr.size() > 0)
         check({tag, "/first_addr"}, q_addr[0], base + row_off(0, h, stride, bu));
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "/rd_req"}, mem_if.rd_req, 0);
      check({tag, "/addr"}, mem_if.addr, 0);
      check({tag, "/busy"}, o_busy, 0);
      check({tag, "/done"}, o_done, 0);
      check({tag, "/found"}, o_found, 0);
      check({tag, "/bounds"}, {o_x_min, o_x_max, o_y_min, o_y_max}, 0);
      check({tag, "/fg_count"}, o_fg_count, 0);
   endtask

   initial begin
      int w, h;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;

      fill_img(8'd255);
      img[1][2][0] = 8'd10;
      run_scan("topdown_4x2", 4, 2, 'h100, 250, 0, 0, 0, 0, 0);

      fill_img(8'd255);
      img[1][1][0] = 8'd0; img[1][1][1] = 8'd0; img[1][1][2] = 8'd0;
      run_scan("bottomup_pad", 3, 2, 'h200, 128, 1, 1, 1, 0, 0);

      fill_img(8'd255);
      img[0][0][0] = 8'd0; img[0][0][1] = 8'd0;
      run_scan("any_ch", 3, 3, 'h040, 128, 0, 0, 0, 0, 0);
      run_scan("all_ch", 3, 3, 'h040, 128, 0, 0, 1, 0, 0);

      fill_img(8'd255);
      img[0][0][0] = 8'd100; img[0][0][1] = 8'd100; img[0][0][2] = 8'd100;
      img[0][1][0] = 8'd99;
      run_scan("thr_edge", 2, 1, 'h300, 100, 0, 0, 0, 0, 0);

      fill_img(8'd255);
      img[3][1][0] = 8'd0; img[3][1][1] = 8'd0; img[3][1][2] = 8'd0;
      img[0][4][0] = 8'd0; img[0][4][1] = 8'd0; img[0][4][2] = 8'd0;
      run_scan("stall_5x5", 5, 5, 'h080, 128, 0, 0, 1, 50, 0);

      run_scan("width0", 0, 3, 'h100, 128, 0, 0, 0, 0, 0);
      run_scan("height0", 2, 0, 'h100, 128, 1, 1, 0, 0, 0);

      rand_img(4, 4, 128);
      run_scan("start_ignored", 4, 4, 'h120, 128, 0, 0, 0, 0, 1);

      for (int t = 0; t < 6; t++) begin
         w = $urandom_range(1, 6);
         h = $urandom_range(1, 6);
         rand_img(w, h, 120);
         run_scan($sformatf("rand%0d", t), w, h, $urandom_range(0, 1200), 120,
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  $urandom_range(0, 60), 0);
      end

      fill_img(8'd0);
      load_mem(5, 5, 'h100, 15, 0);
      stall_pct = 20;
      start_scan(5, 5, 'h100, 128, 0, 0, 0);
      repeat (12) @(negedge clk);
      check("pre_reset/found", o_found, 1);
      #2 rst = 1'b1;
      #1 check_zero_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      w = $urandom_range(2, 6);
      h = $urandom_range(2, 6);
      rand_img(w, h, 140);
      run_scan("after_reset", w, h, 'h180, 140, 1, 1, 0, 30, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
